seven_segment_decoder: RTL
==========================

Name: seven_segment_decoder

Overview:
Inverse of the team's seven-segment encoder. Samples an 8-bit segment bus in pgfedcba order, for example pins driven by an external display driver or by a loop-back of our own encoder output. It synchronises the bus, filters glitches until the pattern is stable, and decodes it back to the 5-bit value (dot, hex nibble). Each decoded value is delivered on a valid/ready output with error and overrun reporting.

Parameters:
STABLE_CYCLES, 4, number of consecutive identical enabled samples required before a pattern is accepted; legal range 1..255.

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
segments_i  input  8  segment bus, bit order pgfedcba, may be asynchronous to clk_i
sample_en_i  input  1  sample strobe; the filter advances only on cycles where this is high
value_o  output  5  decoded value: {p, hex nibble}
error_o  output  1  high with valid_o when the accepted pattern is not a legal glyph
valid_o  output  1  output event pending
ready_i  input  1  consumer accepts the event when valid_o && ready_i
overrun_o  output  1  sticky; set when an event is dropped

Behaviour:
- Reset (rst_ni low at a clock edge; synchronous only): sync flops, candidate, count, value_o, error_o, valid_o and overrun_o all go to 0. last_emitted is set to NONE. Reset mid-settling discards the candidate and emits nothing.
- Synchroniser: 2 flops, clocked every cycle regardless of sample_en_i. s2 is the sampled pattern.
- Filter, on each cycle with sample_en_i = 1:
  - s2 != candidate, or count == 0: candidate <= s2, count <= 1.
  - s2 == candidate: count <= min(count+1, STABLE_CYCLES).
  - The pattern is accepted on the edge where count becomes STABLE_CYCLES. This includes the loading edge when STABLE_CYCLES = 1.
  - A held stable pattern is not re-accepted; count saturates.
- Filter states: EMPTY (count 0), SETTLING (0 < count < STABLE_CYCLES), STABLE. Any differing sample returns to SETTLING.
- On acceptance:
  - pattern[6:0] == 0 (blank, dot ignored): no event; last_emitted <= BLANK.
  - Otherwise, if pattern != last_emitted: generate an event and set last_emitted <= pattern. Repeated identical digits therefore need an intervening blank or different pattern.
- Decode:
  - pattern[6:0] matches one of the 16 hex glyphs: value = {pattern[7], nibble}, error = 0.
  - No match: value = {pattern[7], 4'h0}, error = 1.
- Output register (value_o, error_o, valid_o):
  - Event with valid_o = 0, or valid_o && ready_i in the same cycle: load the event, valid_o <= 1.
  - Event with valid_o && !ready_i: event dropped, overrun_o <= 1, held output unchanged.
  - No event with valid_o && ready_i: valid_o <= 0; value_o and error_o hold their last values.
  - value_o and error_o are stable while valid_o && !ready_i.
- Latency: with sample_en_i tied high and segments_i changing before edge 0, valid_o rises after edge STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges (6 for default).
- Accept rate: at most one event per STABLE_CYCLES enabled samples.

Decomposition:
- Package seven_segment_pkg:
  - 16-entry gfedcba glyph constant array, shared with and moved out of the encoder.
  - BLANK pattern constant.
  - Filter state enum.
- Sub-module seven_segment_lookup (combinational): 7-bit pattern in; hit and 4-bit nibble out. The encoder and this decoder must agree on the same table.

Test Plan:
- Reset, sample_en_i=1, ready_i=1, segments_i=8'h3F held -> valid_o high exactly one cycle, first seen after edge 5; value_o=5'h00, error_o=0.
- segments_i=8'hF7 held -> single event value_o=5'h1A, error_o=0; holding it 100 more cycles -> no further events.
- 8'h06 for 2 cycles, then 8'h5B held -> exactly one event, value_o=5'h02, no 5'h01; then 8'h00 held and 8'h5B again -> second 5'h02 event.
- 8'h49 held -> value_o=5'h00, error_o=1; then 8'hC9 held -> value_o=5'h10, error_o=1.
- ready_i=0; 8'h4F held then 8'h66 held -> valid_o stays high with value_o=5'h03, overrun_o=1. Raise ready_i -> handshake completes, valid_o drops, 5'h04 is never delivered. overrun_o stays 1 until reset.
- STABLE_CYCLES=1 and sample_en_i pulsed every 3rd cycle: filter advances only on strobe cycles. Separately, reset during SETTLING with default STABLE_CYCLES -> no event; all outputs 0 after the reset edge.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: the hex glyph table used by both the
// encoder and the decoder, the blank pattern, and the decoder filter states.
package seven_segment_pkg;

  // Index is the hex nibble; bit order gfedcba.
  localparam logic [6:0] GLYPHS [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] PATTERN_BLANK = 8'h00;
  // NONE and BLANK may share an encoding: neither can equal a non-blank
  // pattern, and only non-blank patterns are compared against last_emitted.
  localparam logic [7:0] PATTERN_NONE  = 8'h00;

  typedef enum logic [1:0] {
    FILT_EMPTY    = 2'd0,
    FILT_SETTLING = 2'd1,
    FILT_STABLE   = 2'd2
  } filter_state_e;

endpackage

// File: rtl/seven_segment_lookup.sv
// Reverse glyph lookup: maps a gfedcba pattern back to its hex nibble.
module seven_segment_lookup
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       hit_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    hit_o    = 1'b0;
    nibble_o = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == GLYPHS[i]) begin
        hit_o    = 1'b1;
        nibble_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Synchronises a pgfedcba segment bus, waits for a stable pattern and
// delivers the decoded {dot, nibble} on a valid/ready output.
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] segments_i,
  input  logic       sample_en_i,
  output logic [4:0] value_o,
  output logic       error_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       overrun_o
);

  // Handshake: an event is transferred on a rising clk_i edge where
  // valid_o && ready_i; value_o/error_o hold steady while valid_o && !ready_i.

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [7:0] sync1_q, sync2_q;
  logic [7:0] cand_q, cand_d;
  logic [7:0] count_q, count_d;
  logic [7:0] last_q, last_d;
  logic [4:0] value_q, value_d;
  logic       error_q, error_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;

  filter_state_e filter_state;
  logic          accept;
  logic          is_blank;
  logic          evt;
  logic          hit;
  logic [3:0]    nibble;

  always_comb begin
    if (count_q == 8'd0)             filter_state = FILT_EMPTY;
    else if (count_q < STABLE_MAX)   filter_state = FILT_SETTLING;
    else                             filter_state = FILT_STABLE;
  end

  always_comb begin
    cand_d  = cand_q;
    count_d = count_q;
    accept  = 1'b0;
    if (sample_en_i) begin
      if (filter_state == FILT_EMPTY || sync2_q != cand_q) begin
        cand_d  = sync2_q;
        count_d = 8'd1;
        accept  = (STABLE_MAX == 8'd1);
      end else if (filter_state == FILT_SETTLING) begin
        count_d = count_q + 8'd1;
        accept  = ((count_q + 8'd1) == STABLE_MAX);
      end
    end
  end

  seven_segment_lookup u_lookup (
    .pattern_i (sync2_q[6:0]),
    .hit_o     (hit),
    .nibble_o  (nibble)
  );

  // On every accepting edge the accepted pattern is sync2_q itself.
  assign is_blank = (sync2_q[6:0] == 7'h00);
  assign evt      = accept && !is_blank && (sync2_q != last_q);

  always_comb begin
    last_d = last_q;
    if (accept) begin
      if (is_blank)  last_d = PATTERN_BLANK;
      else if (evt)  last_d = sync2_q;
    end
  end

  always_comb begin
    value_d   = value_q;
    error_d   = error_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (evt) begin
      if (!valid_q || ready_i) begin
        value_d = {sync2_q[7], hit ? nibble : 4'h0};
        error_d = !hit;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q   <= 8'h00;
      sync2_q   <= 8'h00;
      cand_q    <= 8'h00;
      count_q   <= 8'd0;
      last_q    <= PATTERN_NONE;
      value_q   <= 5'h00;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= segments_i;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      count_q   <= count_d;
      last_q    <= last_d;
      value_q   <= value_d;
      error_q   <= error_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign value_o   = value_q;
  assign error_o   = error_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule
